// File: rtl/memory_access_cycle.sv
// memory_access_cycle: MEM stage; drives the data-memory port, aligns store data,
// extracts and extends load data, and registers results into the M/W register.
// Latency: 1 cycle when no wait states, N+1 cycles with N wait states.
// Backpressure: StallM is raised while an aligned access waits on DMemReady.
// Optional feature macro: DMEM_TIMEOUT_EN (aborts an access after TIMEOUT_CYCLES waits).
module memory_access_cycle #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] StoreCounterOutM,
  input  logic [5:0]  ALUSelectM,
  input  logic [4:0]  WriteAddressM,
  input  logic        RegWriteM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        JtypeM,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  output logic [3:0]  DMemByteEn,
  output logic        DMemRead,
  output logic        DMemWrite,
  input  logic [31:0] DMemRData,
  input  logic        DMemReady,
  output logic        StallM,
  output logic        MisalignedW,
  output logic        MemFaultW,
  output logic [31:0] ALUOutW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  WriteAddressW,
  output logic        RegWriteW,
  output logic        MemToRegW,
  output logic        JtypeW
);

  localparam logic [5:0] OP_LB  = 6'b001011;
  localparam logic [5:0] OP_LH  = 6'b001100;
  localparam logic [5:0] OP_LW  = 6'b001101;
  localparam logic [5:0] OP_LBU = 6'b001110;
  localparam logic [5:0] OP_LHU = 6'b001111;
  localparam logic [5:0] OP_SB  = 6'b010000;
  localparam logic [5:0] OP_SH  = 6'b010001;
  localparam logic [5:0] OP_SW  = 6'b010010;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q;
  logic [31:0] alu_out_w_q;
  logic [31:0] read_data_w_q;
  logic [4:0]  write_addr_w_q;
  logic        reg_write_w_q;
  logic        mem_to_reg_w_q;
  logic        jtype_w_q;
  logic        misaligned_w_q;

  logic        is_load;
  logic        is_store;
  logic        size_b;
  logic        size_h;
  logic        size_w;
  logic        rd_req;
  logic        wr_req;
  logic        misaligned;
  logic        access;
  logic        timeout;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [3:0]  byte_en;
  logic [31:0] wdata;

  // Op-code decode into access kind and width
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size_b   = 1'b0;
    size_h   = 1'b0;
    size_w   = 1'b0;
    case (ALUSelectM)
      OP_LB, OP_LBU: begin is_load  = 1'b1; size_b = 1'b1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; size_h = 1'b1; end
      OP_LW:         begin is_load  = 1'b1; size_w = 1'b1; end
      OP_SB:         begin is_store = 1'b1; size_b = 1'b1; end
      OP_SH:         begin is_store = 1'b1; size_h = 1'b1; end
      OP_SW:         begin is_store = 1'b1; size_w = 1'b1; end
      default: ;
    endcase
  end

  // A write request takes priority; a read is only issued when no write is asked for
  assign wr_req     = MemWriteM & is_store;
  assign rd_req     = MemReadM & ~MemWriteM & is_load;
  assign misaligned = (rd_req | wr_req) &
                      ((size_h & ALUOutM[0]) | (size_w & (ALUOutM[1:0] != 2'b00)));
  assign access     = (rd_req | wr_req) & ~misaligned;

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       mem_fault_w_q;
  assign timeout   = (state_q == S_WAIT) & ~DMemReady &
                     (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign MemFaultW = mem_fault_w_q;
`else
  assign timeout   = 1'b0;
  assign MemFaultW = 1'b0;
`endif

  // Byte-lane enables and replicated store data for the addressed lanes
  always_comb begin
    byte_en = 4'b0000;
    wdata   = StoreCounterOutM;
    if (size_b) begin
      byte_en = 4'b0001 << ALUOutM[1:0];
      wdata   = {4{StoreCounterOutM[7:0]}};
    end else if (size_h) begin
      byte_en = ALUOutM[1] ? 4'b1100 : 4'b0011;
      wdata   = {2{StoreCounterOutM[15:0]}};
    end else if (size_w) begin
      byte_en = 4'b1111;
    end
  end

  // Pick the addressed byte/half of the read word and extend it
  always_comb begin
    case (ALUOutM[1:0])
      2'd0:    ld_byte = DMemRData[7:0];
      2'd1:    ld_byte = DMemRData[15:8];
      2'd2:    ld_byte = DMemRData[23:16];
      default: ld_byte = DMemRData[31:24];
    endcase
    ld_half = ALUOutM[1] ? DMemRData[31:16] : DMemRData[15:0];
    case (ALUSelectM)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'b0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'b0, ld_half};
      OP_LW:   ld_ext = DMemRData;
      default: ld_ext = 32'b0;
    endcase
  end

  // Memory port: strobes follow the held M-stage inputs in both IDLE and WAIT
  assign DMemAddr   = {ALUOutM[31:2], 2'b00};
  assign DMemWData  = wdata;
  assign DMemByteEn = (access & ~RESET) ? byte_en : 4'b0000;
  assign DMemRead   = access & rd_req & ~timeout & ~RESET;
  assign DMemWrite  = access & wr_req & ~timeout & ~RESET;
  assign StallM     = access & ~DMemReady & ~timeout & ~RESET;

  // FSM, wait counter and M/W pipeline register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= S_IDLE;
      alu_out_w_q    <= 32'b0;
      read_data_w_q  <= 32'b0;
      write_addr_w_q <= 5'b0;
      reg_write_w_q  <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
      jtype_w_q      <= 1'b0;
      misaligned_w_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      wait_cnt_q     <= 8'b0;
      mem_fault_w_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE:  if (access & ~DMemReady) state_q <= S_WAIT;
        default: if (~access | DMemReady | timeout) state_q <= S_IDLE;
      endcase
`ifdef DMEM_TIMEOUT_EN
      wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + 8'd1 : 8'd0;
`endif
      if (StallM) begin
        // Bubble: no write-back; event flags are single-cycle so they clear too
        reg_write_w_q  <= 1'b0;
        mem_to_reg_w_q <= 1'b0;
        misaligned_w_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
        mem_fault_w_q  <= 1'b0;
`endif
      end else begin
        alu_out_w_q    <= ALUOutM;
        write_addr_w_q <= WriteAddressM;
        jtype_w_q      <= JtypeM;
        reg_write_w_q  <= RegWriteM & ~is_store & ~misaligned & ~timeout;
        mem_to_reg_w_q <= rd_req & ~misaligned & ~timeout;
        read_data_w_q  <= (access & rd_req & ~timeout) ? ld_ext : 32'b0;
        misaligned_w_q <= misaligned;
`ifdef DMEM_TIMEOUT_EN
        mem_fault_w_q  <= timeout;
`endif
      end
    end
  end

  assign ALUOutW       = alu_out_w_q;
  assign ReadDataW     = read_data_w_q;
  assign WriteAddressW = write_addr_w_q;
  assign RegWriteW     = reg_write_w_q;
  assign MemToRegW     = mem_to_reg_w_q;
  assign JtypeW        = jtype_w_q;
  assign MisalignedW   = misaligned_w_q;

endmodule

// File: tb/tb_memory_access_cycle.sv
// Bench for memory_access_cycle: directed scenarios plus randomized transactions
// checked against a transaction-level model of the MEM stage.
module tb_memory_access_cycle;

  localparam logic [5:0] LB = 6'b001011, LH = 6'b001100, LW = 6'b001101, LBU = 6'b001110,
                         LHU = 6'b001111, SB = 6'b010000, SH = 6'b010001, SW = 6'b010010;
  localparam logic [5:0] ADD = 6'b000000;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] ALUOutM, StoreCounterOutM, DMemRData;
  logic [5:0]  ALUSelectM;
  logic [4:0]  WriteAddressM;
  logic        RegWriteM, MemReadM, MemWriteM, JtypeM, DMemReady;
  logic [31:0] DMemAddr, DMemWData, ALUOutW, ReadDataW;
  logic [3:0]  DMemByteEn;
  logic        DMemRead, DMemWrite, StallM, MisalignedW, MemFaultW;
  logic [4:0]  WriteAddressW;
  logic        RegWriteW, MemToRegW, JtypeW;

  int total = 0;
  int bad = 0;

  memory_access_cycle #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET), .ALUOutM(ALUOutM), .StoreCounterOutM(StoreCounterOutM),
    .ALUSelectM(ALUSelectM), .WriteAddressM(WriteAddressM), .RegWriteM(RegWriteM),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .JtypeM(JtypeM),
    .DMemAddr(DMemAddr), .DMemWData(DMemWData), .DMemByteEn(DMemByteEn),
    .DMemRead(DMemRead), .DMemWrite(DMemWrite), .DMemRData(DMemRData),
    .DMemReady(DMemReady), .StallM(StallM), .MisalignedW(MisalignedW),
    .MemFaultW(MemFaultW), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
    .WriteAddressW(WriteAddressW), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
    .JtypeW(JtypeW)
  );

  always #5 CLK = ~CLK;

  // One M-stage transaction; called just after a rising edge, returns just after one.
  task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                         input logic j, input logic [31:0] rdata, input int waits_in);
    int size, off, waits;
    bit ld, st, sgn, rdacc, wracc, mis, acc;
    logic [31:0] mask, v, exp_wd, exp_rd, exp_addr;
    logic [3:0] exp_en;
    ld  = op inside {LB, LH, LW, LBU, LHU};
    st  = op inside {SB, SH, SW};
    sgn = op inside {LB, LH};
    size = (op inside {LB, LBU, SB}) ? 1 : (op inside {LH, LHU, SH}) ? 2 : 4;
    off = int'(addr[1:0]);
    wracc = st && mw;
    rdacc = ld && mr && !mw;
    mis = (wracc || rdacc) && (off % size != 0);
    acc = (wracc || rdacc) && !mis;
    waits = acc ? waits_in : 0;
    exp_en = acc ? 4'(((1 << size) - 1) << off) : 4'b0000;
    exp_wd = (size == 1) ? {24'b0, sdata[7:0]} * 32'h01010101 :
             (size == 2) ? {16'b0, sdata[15:0]} * 32'h00010001 : sdata;
    exp_addr = addr - 32'(off);
    mask = (size == 4) ? 32'hFFFFFFFF : (32'd1 << (8 * size)) - 32'd1;
    v = (rdata >> (8 * off)) & mask;
    if (sgn && v[8 * size - 1]) v = v | ~mask;
    exp_rd = (acc && rdacc) ? v : 32'b0;

    ALUSelectM = op; ALUOutM = addr; StoreCounterOutM = sdata; WriteAddressM = rd;
    RegWriteM = rw; MemReadM = mr; MemWriteM = mw; JtypeM = j; DMemRData = rdata;
    for (int i = 0; i <= waits; i++) begin
      DMemReady = (i == waits);
      #3;
      total++; if (StallM !== (i < waits)) begin bad++;
        $display("FAIL stall op=%b cyc=%0d got=%b want=%b", op, i, StallM, (i < waits)); end
      total++; if (DMemRead !== (acc && rdacc)) begin bad++;
        $display("FAIL dmem_read op=%b got=%b want=%b", op, DMemRead, (acc && rdacc)); end
      total++; if (DMemWrite !== (acc && wracc)) begin bad++;
        $display("FAIL dmem_write op=%b got=%b want=%b", op, DMemWrite, (acc && wracc)); end
      total++; if (DMemByteEn !== exp_en) begin bad++;
        $display("FAIL byte_en op=%b addr=%h got=%b want=%b", op, addr, DMemByteEn, exp_en); end
      if (acc) begin
        total++; if (DMemAddr !== exp_addr) begin bad++;
          $display("FAIL dmem_addr got=%h want=%h", DMemAddr, exp_addr); end
      end
      if (acc && wracc) begin
        total++; if (DMemWData !== exp_wd) begin bad++;
          $display("FAIL wdata op=%b got=%h want=%h", op, DMemWData, exp_wd); end
      end
      @(posedge CLK); #1;
      if (i < waits) begin
        total++; if (RegWriteW !== 1'b0 || MemToRegW !== 1'b0) begin bad++;
          $display("FAIL bubble cyc=%0d got=%b%b want=00", i, RegWriteW, MemToRegW); end
      end
    end
    total++; if (ALUOutW !== addr) begin bad++;
      $display("FAIL alu_out_w got=%h want=%h", ALUOutW, addr); end
    total++; if (WriteAddressW !== rd) begin bad++;
      $display("FAIL wr_addr_w got=%0d want=%0d", WriteAddressW, rd); end
    total++; if (RegWriteW !== (rw && !st && !mis)) begin bad++;
      $display("FAIL reg_write_w op=%b got=%b want=%b", op, RegWriteW, (rw && !st && !mis)); end
    total++; if (MemToRegW !== (rdacc && !mis)) begin bad++;
      $display("FAIL mem_to_reg_w op=%b got=%b want=%b", op, MemToRegW, (rdacc && !mis)); end
    total++; if (ReadDataW !== exp_rd) begin bad++;
      $display("FAIL read_data_w op=%b addr=%h got=%h want=%h", op, addr, ReadDataW, exp_rd); end
    total++; if (JtypeW !== j || MisalignedW !== mis || MemFaultW !== 1'b0) begin bad++;
      $display("FAIL flags_w got j=%b mis=%b flt=%b want j=%b mis=%b flt=0",
               JtypeW, MisalignedW, MemFaultW, j, mis); end
    DMemReady = 1'b0;
  endtask

  task automatic clear_inputs();
    ALUOutM = '0; StoreCounterOutM = '0; ALUSelectM = ADD; WriteAddressM = '0;
    RegWriteM = 0; MemReadM = 0; MemWriteM = 0; JtypeM = 0; DMemRData = '0; DMemReady = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    ALUOutM = 32'h1234; ALUSelectM = LW; MemReadM = 1; RegWriteM = 1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    total++; if (StallM !== 0 || DMemRead !== 0 || DMemWrite !== 0) begin bad++;
      $display("FAIL reset_port got stall=%b rd=%b wr=%b want 000", StallM, DMemRead, DMemWrite); end
    total++; if ({ALUOutW, ReadDataW, WriteAddressW, RegWriteW, MemToRegW, JtypeW,
                  MisalignedW, MemFaultW} !== '0) begin bad++;
      $display("FAIL reset_w got alu=%h rd=%h wa=%0d rw=%b m2r=%b", ALUOutW, ReadDataW,
               WriteAddressW, RegWriteW, MemToRegW); end
    clear_inputs();
    RESET = 1'b0;
  endtask

  task automatic test_alu_op();
    run_txn(ADD, 32'h8, 32'h0, 5'd10, 1, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic test_store_byte();
    run_txn(SB, 32'h1003, 32'h000000A5, 5'd0, 0, 0, 1, 0, 32'h0, 0);
    run_txn(SH, 32'h1002, 32'h0000BEEF, 5'd0, 0, 0, 1, 0, 32'h0, 1);
    run_txn(SW, 32'h1004, 32'hCAFEF00D, 5'd0, 0, 1, 1, 0, 32'h0, 0);
  endtask

  task automatic test_load_extend();
    run_txn(LB, 32'h1002, 32'h0, 5'd7, 1, 1, 0, 0, 32'h0080FF00, 0);
    total++; if (ReadDataW !== 32'hFFFFFF80 || MemToRegW !== 1'b1) begin bad++;
      $display("FAIL lb_const got=%h m2r=%b want=ffffff80 1", ReadDataW, MemToRegW); end
    run_txn(LBU, 32'h1002, 32'h0, 5'd7, 1, 1, 0, 0, 32'h0080FF00, 0);
    total++; if (ReadDataW !== 32'h00000080) begin bad++;
      $display("FAIL lbu_const got=%h want=00000080", ReadDataW); end
    run_txn(LH, 32'h1002, 32'h0, 5'd8, 1, 1, 0, 0, 32'h8001FF00, 0);
    run_txn(LHU, 32'h1000, 32'h0, 5'd8, 1, 1, 0, 0, 32'h8001FF00, 0);
  endtask

  task automatic test_wait_states();
    run_txn(LW, 32'h2000, 32'h0, 5'd3, 1, 1, 0, 1, 32'hDEADBEEF, 3);
    total++; if (ReadDataW !== 32'hDEADBEEF || RegWriteW !== 1'b1) begin bad++;
      $display("FAIL lw_wait got=%h rw=%b want=deadbeef 1", ReadDataW, RegWriteW); end
  endtask

  task automatic test_misaligned();
    run_txn(LH, 32'h1001, 32'h0, 5'd4, 1, 1, 0, 0, 32'h11223344, 2);
    total++; if (MisalignedW !== 1'b1 || RegWriteW !== 1'b0) begin bad++;
      $display("FAIL lh_mis got mis=%b rw=%b want 1 0", MisalignedW, RegWriteW); end
    run_txn(SW, 32'h1006, 32'h55667788, 5'd0, 0, 0, 1, 0, 32'h0, 2);
  endtask

  task automatic test_reset_mid_wait();
    run_txn(ADD, 32'h77, 32'h0, 5'd9, 1, 0, 0, 1, 32'h0, 0);
    ALUSelectM = LW; ALUOutM = 32'h3000; MemReadM = 1; RegWriteM = 1; WriteAddressM = 5'd12;
    DMemReady = 0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1;
    #3;
    total++; if (StallM !== 0 || DMemRead !== 0) begin bad++;
      $display("FAIL rst_wait_port got stall=%b rd=%b want 0 0", StallM, DMemRead); end
    @(posedge CLK); #1;
    total++; if ({ALUOutW, ReadDataW, WriteAddressW, RegWriteW, MemToRegW, JtypeW,
                  MisalignedW, MemFaultW, StallM} !== '0) begin bad++;
      $display("FAIL rst_wait_w got alu=%h wa=%0d rw=%b j=%b stall=%b", ALUOutW,
               WriteAddressW, RegWriteW, JtypeW, StallM); end
    clear_inputs();
    RESET = 1'b0;
  endtask

  task automatic test_timeout();
`ifdef DMEM_TIMEOUT_EN
    ALUSelectM = LW; ALUOutM = 32'h4000; MemReadM = 1; RegWriteM = 1; DMemReady = 0;
    for (int i = 0; i < 4; i++) begin
      #3;
      total++; if (StallM !== 1'b1) begin bad++;
        $display("FAIL to_stall cyc=%0d got=%b want=1", i, StallM); end
      @(posedge CLK); #1;
    end
    #3;
    total++; if (StallM !== 1'b0) begin bad++;
      $display("FAIL to_drop got=%b want=0", StallM); end
    @(posedge CLK); #1;
    clear_inputs();
    total++; if (MemFaultW !== 1'b1 || RegWriteW !== 1'b0) begin bad++;
      $display("FAIL to_fault got flt=%b rw=%b want 1 0", MemFaultW, RegWriteW); end
    @(posedge CLK); #1;
    total++; if (MemFaultW !== 1'b0) begin bad++;
      $display("FAIL to_fault_pulse got=%b want=0", MemFaultW); end
`else
    run_txn(LW, 32'h4000, 32'h0, 5'd6, 1, 1, 0, 0, 32'h0BADF00D, 20);
`endif
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    logic [5:0] op;
    logic [31:0] addr;
    bit st, ld, mr, mw;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, ADD, 6'h3F};
    for (int n = 0; n < 80; n++) begin
      op = ops[$urandom_range(0, 9)];
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      ld = op inside {LB, LH, LW, LBU, LHU};
      st = op inside {SB, SH, SW};
      mr = ld || (st && $urandom_range(0, 3) == 0);
      mw = st;
      run_txn(op, addr, $urandom, 5'($urandom), 1'($urandom), mr, mw, 1'($urandom),
              $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    RESET = 1'b1;
    clear_inputs();
    test_reset();
    test_alu_op();
    test_store_byte();
    test_load_extend();
    test_wait_states();
    test_misaligned();
    test_reset_mid_wait();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
